// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment scanner.
// Optional: SEG7_LEADING_ZERO_SUPPRESS_EN darkens leading zero digits.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] val_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic                    wrap;
    logic [3:0]              nib;
    logic                    dp_sel;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [6:0]              seg_d;
    logic                    sup;
    logic                    dark;

    assign wrap = (cnt == CW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (wrap) begin
            cnt <= '0;
            if (idx == IW'(NUM_DIGITS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            dp_q  <= '0;
        end else if (load) begin
            val_q <= value;
            dp_q  <= dp_in;
        end
    end

    always_comb begin
        nib    = 4'h0;
        dp_sel = 1'b0;
        an_d   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib     = val_q[4*i +: 4];
                dp_sel  = dp_q[i];
                an_d[i] = 1'b0;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_SUPPRESS_EN
    // digit i>0 is dark when it and every higher nibble are zero
    always_comb begin
        sup = 1'b0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                sup = ((val_q >> (4*i)) == '0);
            end
        end
    end
`else
    assign sup = 1'b0;
`endif

    always_comb begin
        seg_d = 7'b1111111;
        unique case (nib)
            4'h0: seg_d = 7'b0000001;
            4'h1: seg_d = 7'b1001111;
            4'h2: seg_d = 7'b0010010;
            4'h3: seg_d = 7'b0000110;
            4'h4: seg_d = 7'b1001100;
            4'h5: seg_d = 7'b0100100;
            4'h6: seg_d = 7'b0100000;
            4'h7: seg_d = 7'b0001111;
            4'h8: seg_d = 7'b0000000;
            4'h9: seg_d = 7'b0000100;
            4'hA: seg_d = 7'b0001000;
            4'hB: seg_d = 7'b1100000;
            4'hC: seg_d = 7'b0110001;
            4'hD: seg_d = 7'b1000010;
            4'hE: seg_d = 7'b0110000;
            4'hF: seg_d = 7'b0111000;
        endcase
    end

    assign dark = blank_in | sup;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else if (dark) begin
            an  <= '1;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= ~dp_sel;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver.
// Honours SEG7_LEADING_ZERO_SUPPRESS_EN when predicting outputs.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam logic [11:0] DARK = 12'hFFF;
    localparam logic [6:0] SEGTAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct {
        logic [11:0] v;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_in = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    int          e = 0;
    logic [15:0] sh_v = '0;
    logic [3:0]  sh_d = '0;

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .dp_in(dp_in), .blank_in(blank_in),
        .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    // outputs at edge ev reflect the digit selected after ev-1 edges
    function automatic logic [11:0] predict(int ev, logic [15:0] v,
                                            logic [3:0] d, logic b);
        int         k;
        logic [3:0] nb;
        logic [3:0] a;
        k = ((ev - 1) / RD) % N;
        nb = v[4*k +: 4];
        a = 4'hF;
        a[k] = 1'b0;
        if (b) return DARK;
`ifdef SEG7_LEADING_ZERO_SUPPRESS_EN
        if (k > 0 && (v >> (4*k)) == 16'h0) return DARK;
`endif
        return {a, SEGTAB[nb], ~d[k]};
    endfunction

    task automatic push(logic [11:0] v, string nm);
        exp_t t;
        t.v = v;
        t.nm = nm;
        expq.push_back(t);
    endtask

    task automatic reset_cycles(int n, string nm);
        repeat (n) begin
            @(negedge clk);
            rst_n = 1'b0;
            load = 1'b0;
            blank_in = 1'b0;
            push(DARK, nm);
        end
        sh_v = '0;
        sh_d = '0;
        e = 0;
    endtask

    task automatic cyc(logic ld, logic [15:0] v, logic [3:0] d,
                       logic b, string nm);
        @(negedge clk);
        rst_n = 1'b1;
        load = ld;
        value = v;
        dp_in = d;
        blank_in = b;
        e++;
        push(predict(e, sh_v, sh_d, b), nm);
        if (ld) begin
            sh_v = v;
            sh_d = d;
        end
    endtask

    initial begin : monitor
        exp_t t;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (expq.size() > 0) begin
                t = expq.pop_front();
                checks++;
                if ({an, seg, dp} !== t.v) begin
                    errors++;
                    $display("FAIL %s t=%0t got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                             t.nm, $time, an, seg, dp,
                             t.v[11:8], t.v[7:1], t.v[0]);
                end
            end
        end
    end

    initial begin : driver
        reset_cycles(3, "reset");
        cyc(1'b0, 16'h0000, 4'h0, 1'b0, "first_edge");
        cyc(1'b1, 16'h1A2F, 4'b0100, 1'b0, "load_1a2f");
        while (e < 21) cyc(1'b0, 16'hBEEF, 4'hF, 1'b0, "scan");
        cyc(1'b1, 16'h0050, 4'h0, 1'b0, "load_0050");
        while (e < 35) cyc(1'b0, 16'h9999, 4'hF, 1'b0, "hold");
        cyc(1'b1, 16'h0070, 4'h0, 1'b0, "load_on_advance");
        while (e < 37) cyc(1'b0, 16'h0000, 4'h0, 1'b0, "post_adv");
        repeat (10) cyc(1'b0, 16'h0000, 4'h0, 1'b1, "blank");
        while (e < 52) cyc(1'b0, 16'h0000, 4'h0, 1'b0, "unblank");
        cyc(1'b1, 16'h0000, 4'h0, 1'b0, "load_0000");
        while (e < 74) cyc(1'b0, 16'h1234, 4'h0, 1'b0, "zeros");
        @(negedge clk);
        load = 1'b0;
        push(DARK, "async_rst");
        #2 rst_n = 1'b0;
        push(DARK, "in_rst");
        reset_cycles(2, "in_rst");
        while (e < 16) cyc(1'b0, 16'hFFFF, 4'hF, 1'b0, "restart");
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
